// File: rtl/stream_pack_buffer.sv
// Packs DSIZE-bit pixels into MSIZE-bit words (PSIZE-bit slots) with sof/eol/eof side-band flags,
// and buffers the words in a DEPTH-entry synchronous FIFO that the VDMA write master drains.
module stream_pack_buffer #(
    parameter int DSIZE    = 24,
    parameter int PSIZE    = 32,
    parameter int MSIZE    = 128,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     falign,
    input  logic                     lalign,
    input  logic                     ealign,
    input  logic                     idata_vld,
    input  logic [DSIZE-1:0]         idata,
    output logic                     fifo_almost_full,
    input  logic                     rd_en,
    output logic [MSIZE-1:0]         rd_data,
    output logic                     rd_sof,
    output logic                     rd_eol,
    output logic                     rd_eof,
    output logic                     rd_empty,
    output logic [$clog2(DEPTH):0]   rd_count,
    output logic                     overflow,
    output logic                     frame_err,
    output logic                     frame_done
);
    localparam int N  = MSIZE / PSIZE;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = MSIZE + 3;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(DEPTH - AF_LEVEL);

    // packer state
    logic [MSIZE-1:0] r_asm;
    logic [SW-1:0]    r_slot;
    logic             r_sof;

    logic [MSIZE-1:0] w_asm;
    logic [SW-1:0]    w_slot;
    logic             w_sof;
    logic             w_has;
    logic             w_discard;
    logic             w_eol;
    logic             w_eof;
    logic             w_push;

    // fifo state
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_rd_pend;
    logic [AW-1:0]    r_rd_addr;
    logic [EW-1:0]    r_rd_word;
    logic             r_af;
    logic             r_overflow;
    logic             r_frame_err;
    logic             r_frame_done;

    logic             w_wr_ok;
    logic             w_rd_ok;

    // A falign pixel always restarts the word at slot 0; any partial word is thrown away,
    // so the falign cycle can never also need a push of the old contents.
    always_comb begin
        w_discard = idata_vld && falign && (r_slot != '0);
        w_slot    = (idata_vld && falign) ? '0 : r_slot;
        w_asm     = w_discard ? '0 : r_asm;
        w_sof     = w_discard ? 1'b0 : r_sof;
        w_has     = idata_vld || ((r_slot != '0) && !w_discard);
        if (idata_vld) begin
            for (int i = 0; i < N; i++) begin
                if (w_slot == SW'(i)) begin
                    w_asm[i*PSIZE +: PSIZE] = PSIZE'(idata);
                end
            end
            if (w_slot == '0) begin
                w_sof = falign;
            end
        end
        w_eol  = idata_vld && lalign;
        w_eof  = ealign && w_has;
        w_push = (idata_vld && (w_slot == LAST_SLOT)) || w_eol || w_eof;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_asm        <= '0;
            r_slot       <= '0;
            r_sof        <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_asm  <= '0;
                r_slot <= '0;
                r_sof  <= 1'b0;
            end else if (idata_vld) begin
                r_asm  <= w_asm;
                r_slot <= w_slot + 1'b1;
                r_sof  <= w_sof;
            end
            if (w_discard) begin
                r_frame_err <= 1'b1;
            end
            r_frame_done <= ealign;
        end
    end

    // Fullness is judged on the stored count only; a same-cycle read does not make room.
    assign w_wr_ok = w_push && (r_count != FULL_CNT);
    assign w_rd_ok = rd_en && (r_count != '0);

    always_ff @(posedge aclk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= {w_sof, w_eol, w_eof, w_asm};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_word  <= '0;
            r_af       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_addr <= r_rptr;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The entry is copied out one edge after the read is accepted.
            r_rd_pend <= w_rd_ok;
            if (r_rd_pend) begin
                r_rd_word <= r_mem[r_rd_addr];
            end
            r_af <= (r_count >= AF_CNT);
            if (w_push && (r_count == FULL_CNT)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data          = r_rd_word[MSIZE-1:0];
    assign rd_sof           = r_rd_word[MSIZE+2];
    assign rd_eol           = r_rd_word[MSIZE+1];
    assign rd_eof           = r_rd_word[MSIZE];
    assign rd_empty         = (r_count == '0);
    assign rd_count         = r_count;
    assign fifo_almost_full = r_af;
    assign overflow         = r_overflow;
    assign frame_err        = r_frame_err;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_stream_pack_buffer.sv
// Directed bench for stream_pack_buffer: expected words are queued at stimulus time and a
// monitor pops and compares each word as the read port presents it.
module tb_stream_pack_buffer;
    localparam int DSIZE = 24;
    localparam int PSIZE = 32;
    localparam int MSIZE = 128;
    localparam int DEPTH = 16;
    localparam int AF_LEVEL = 4;
    localparam int EW = MSIZE + 3;

    logic             aclk;
    logic             aresetn;
    logic             falign;
    logic             lalign;
    logic             ealign;
    logic             idata_vld;
    logic [DSIZE-1:0] idata;
    logic             fifo_almost_full;
    logic             rd_en;
    logic [MSIZE-1:0] rd_data;
    logic             rd_sof;
    logic             rd_eol;
    logic             rd_eof;
    logic             rd_empty;
    logic [4:0]       rd_count;
    logic             overflow;
    logic             frame_err;
    logic             frame_done;

    int n_chk = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    stream_pack_buffer #(
        .DSIZE(DSIZE), .PSIZE(PSIZE), .MSIZE(MSIZE), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .falign(falign), .lalign(lalign), .ealign(ealign),
        .idata_vld(idata_vld), .idata(idata),
        .fifo_almost_full(fifo_almost_full),
        .rd_en(rd_en), .rd_data(rd_data),
        .rd_sof(rd_sof), .rd_eol(rd_eol), .rd_eof(rd_eof),
        .rd_empty(rd_empty), .rd_count(rd_count),
        .overflow(overflow), .frame_err(frame_err), .frame_done(frame_done)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // read-side monitor: accepted read at edge T -> word valid after edge T+1
    logic mon_acc;
    logic mon_chk;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mon_acc <= 1'b0;
            mon_chk <= 1'b0;
        end else begin
            mon_acc <= rd_en && !rd_empty;
            mon_chk <= mon_acc;
        end
    end

    always @(negedge aclk) begin
        logic [EW-1:0] exp_w;
        logic [EW-1:0] act_w;
        if (aresetn && mon_chk) begin
            act_w = {rd_sof, rd_eol, rd_eof, rd_data};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_word: unexpected word got=%h", act_w);
            end else begin
                exp_w = exp_q.pop_front();
                if (act_w !== exp_w) begin
                    n_err++;
                    $display("FAIL rd_word: got=%h exp=%h", act_w, exp_w);
                end
            end
        end
    end

    // driver tasks
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vld, input logic [DSIZE-1:0] d,
                       input logic f, input logic l, input logic e);
        @(negedge aclk);
        idata_vld = vld;
        idata     = d;
        falign    = f;
        lalign    = l;
        ealign    = e;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [MSIZE-1:0] pack4(input logic [23:0] a, input logic [23:0] b,
                                               input logic [23:0] c, input logic [23:0] d);
        return {8'h0, d, 8'h0, c, 8'h0, b, 8'h0, a};
    endfunction

    task automatic push_exp(input logic s, input logic l, input logic e,
                            input logic [MSIZE-1:0] w);
        exp_q.push_back({s, l, e, w});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            rd_en = 1'b1;
        end
        @(negedge aclk);
        rd_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge aclk);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: pending=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"}, 64'(rd_empty), 64'd1);
        chk({tag, "_count"}, 64'(rd_count), 64'd0);
        chk({tag, "_data"}, 64'(rd_data[63:0] | rd_data[127:64]), 64'd0);
        chk({tag, "_flags"}, 64'({rd_sof, rd_eol, rd_eof}), 64'd0);
        chk({tag, "_af"}, 64'(fifo_almost_full), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_ferr"}, 64'(frame_err), 64'd0);
        chk({tag, "_fdone"}, 64'(frame_done), 64'd0);
    endtask

    // stimulus
    initial begin
        aresetn   = 1'b0;
        rd_en     = 1'b0;
        idata_vld = 1'b0;
        idata     = '0;
        falign    = 1'b0;
        lalign    = 1'b0;
        ealign    = 1'b0;
        repeat (3) @(negedge aclk);
        chk_reset_vals("reset");
        aresetn = 1'b1;

        // full words with falign on the first pixel
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DSIZE'(i), (i == 1), 1'b0, 1'b0);
        end
        idle();
        chk("full_count", 64'(rd_count), 64'd2);
        push_exp(1'b1, 1'b0, 1'b0, 128'h00000004_00000003_00000002_00000001);
        push_exp(1'b0, 1'b0, 1'b0, 128'h00000008_00000007_00000006_00000005);
        drain(2);
        chk("full_empty", 64'(rd_empty), 64'd1);

        // 6-pixel line
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, DSIZE'(i), (i == 1), (i == 6), 1'b0);
        end
        idle();
        chk("line_count", 64'(rd_count), 64'd2);
        push_exp(1'b1, 1'b0, 1'b0, 128'h00000004_00000003_00000002_00000001);
        push_exp(1'b0, 1'b1, 1'b0, 128'h00000000_00000000_00000006_00000005);
        drain(2);

        // frame end after 3 pixels, then a second ealign on an empty register
        cyc(1'b1, 24'h000021, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000022, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000023, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("eof_count", 64'(rd_count), 64'd1);
        chk("eof_fdone_hi", 64'(frame_done), 64'd1);
        idle();
        chk("eof_fdone_lo", 64'(frame_done), 64'd0);
        push_exp(1'b0, 1'b0, 1'b1, pack4(24'h21, 24'h22, 24'h23, 24'h0));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("eof2_count", 64'(rd_count), 64'd1);
        chk("eof2_fdone", 64'(frame_done), 64'd1);
        // lalign and ealign with the same pixel
        cyc(1'b1, 24'h000031, 1'b0, 1'b1, 1'b1);
        idle();
        chk("eoleof_count", 64'(rd_count), 64'd2);
        push_exp(1'b0, 1'b1, 1'b1, pack4(24'h31, 24'h0, 24'h0, 24'h0));
        drain(2);

        // early falign discards the partial word
        cyc(1'b1, 24'h000041, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000042, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
        idle();
        chk("efa_count", 64'(rd_count), 64'd0);
        chk("efa_ferr", 64'(frame_err), 64'd1);
        cyc(1'b1, 24'h000044, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000045, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000046, 1'b0, 1'b0, 1'b0);
        idle();
        chk("efa_count2", 64'(rd_count), 64'd1);
        push_exp(1'b1, 1'b0, 1'b0, pack4(24'hABCDEF, 24'h44, 24'h45, 24'h46));
        drain(1);

        // fill to full and overflow
        for (int w = 1; w <= 17; w++) begin
            for (int s = 0; s < 4; s++) begin
                cyc(1'b1, DSIZE'(w * 16 + s), 1'b0, 1'b0, 1'b0);
            end
            idle();
            chk($sformatf("fill_count_w%0d", w), 64'(rd_count), 64'((w > 16) ? 16 : w));
            chk($sformatf("fill_af_w%0d", w), 64'(fifo_almost_full), 64'((w - 1) >= 12));
            chk($sformatf("fill_ovf_w%0d", w), 64'(overflow), 64'(w == 17));
            if (w <= 16) begin
                push_exp(1'b0, 1'b0, 1'b0,
                         pack4(24'(w * 16), 24'(w * 16 + 1), 24'(w * 16 + 2), 24'(w * 16 + 3)));
            end
            if (w == 12) begin
                idle();
                chk("fill_af_rise", 64'(fifo_almost_full), 64'd1);
            end
        end
        drain(16);
        chk("fill_empty", 64'(rd_empty), 64'd1);
        chk("fill_count0", 64'(rd_count), 64'd0);
        chk("fill_ovf_sticky", 64'(overflow), 64'd1);

        // reset mid-stream loses stored and partial words
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, DSIZE'(24'h50 + i), 1'b0, 1'b0, 1'b0);
        end
        idle();
        chk("mid_count", 64'(rd_count), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        cyc(1'b1, 24'h000061, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 24'h000062, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000063, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h000064, 1'b0, 1'b0, 1'b0);
        idle();
        chk("post_count", 64'(rd_count), 64'd1);
        chk("post_ferr", 64'(frame_err), 64'd0);
        push_exp(1'b1, 1'b0, 1'b0, pack4(24'h61, 24'h62, 24'h63, 24'h64));
        drain(1);

        repeat (2) @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_pack_buffer.md
# stream_pack_buffer

Packs the pixel stream produced by the stream input port (falign/lalign/ealign/data-valid/data) into wide memory words and buffers them in a synchronous FIFO. The VDMA write master drains the FIFO. Frame and line boundaries travel with each word as side-band flags. The FIFO occupancy is fed back to the stream input port as `fifo_almost_full`.

## Interface
- `DSIZE`, 24: pixel width; must satisfy DSIZE ≤ PSIZE.
- `PSIZE`, 32: pixel slot width inside a word; the upper PSIZE-DSIZE bits of each slot are zero.
- `MSIZE`, 128: memory word width. N = MSIZE/PSIZE slots per word; MSIZE must be a multiple of PSIZE.
- `DEPTH`, 16: FIFO depth in words; must be a power of two.
- `AF_LEVEL`, 4: almost-full margin in words.
- `aclk`  in  1  clock; all logic rises on this edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `falign`  in  1  first pixel of frame; qualified by `idata_vld`.
- `lalign`  in  1  last pixel of line; qualified by `idata_vld`.
- `ealign`  in  1  single-cycle end-of-frame pulse; not qualified by `idata_vld`.
- `idata_vld`  in  1  pixel valid.
- `idata`  in  DSIZE  pixel data.
- `fifo_almost_full`  out  1  registered; high when count ≥ DEPTH-AF_LEVEL.
- `rd_en`  in  1  read request.
- `rd_data`  out  MSIZE  packed word.
- `rd_sof`, `rd_eol`, `rd_eof`  out  1 each  flags for `rd_data`.
- `rd_empty`  out  1  FIFO empty.
- `rd_count`  out  log2(DEPTH)+1  words stored.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a partial word was discarded on `falign`.
- `frame_done`  out  1  one-cycle pulse, registered from `ealign`.

## Operation
**Packer**
- Slot counter `slot` runs 0..N-1.
- An accepted pixel (`idata_vld`=1) is written to bits [slot*PSIZE +: DSIZE] of the assembly register. The rest of that slot is zero.
- A push of the assembly register happens when any of these holds:
  - the pixel lands in slot N-1;
  - `lalign` is high with the pixel;
  - `ealign` is high and the register holds at least one pixel (including a pixel accepted in the same cycle).
- After a push, `slot` goes to 0 and the assembly register is cleared to zero. Unused slots in a pushed word read as zero.
- Flags are latched per word:
  - sof = the word's slot-0 pixel carried `falign`;
  - eol = push caused by `lalign`;
  - eof = push caused by `ealign`.
- A push can carry any combination of eol and eof, e.g. `lalign` and `ealign` in the same cycle give eol=1, eof=1.
- `falign` with `slot`≠0: the pending partial word is discarded (no push) and `frame_err` is set. The falign pixel then goes to slot 0 with sof=1.
- At most one push per cycle. The discard rule guarantees this.
- `ealign` with an empty assembly register: no push. `frame_done` still pulses.

**FIFO**
- MSIZE+3 bits wide; stores data plus sof/eol/eof.
- Binary pointers wrap at DEPTH.
- Push while count==DEPTH: the word is dropped and `overflow` is set. Fullness is judged on count alone, so a push is dropped even if `rd_en` is high in the same cycle.
- `rd_en` while empty is ignored.
- A simultaneous push and read with 0<count<DEPTH leaves count unchanged.

## Timing
- **Reset values:**
  - `rd_data`=0; all flags 0;
  - `rd_empty`=1, `rd_count`=0;
  - `fifo_almost_full`=0, `overflow`=0, `frame_err`=0, `frame_done`=0;
  - `slot`=0; pointers 0.
- Reset asserted mid-operation loses all stored and partial words immediately.
- **Push latency:** the pixel completing a word at edge T is counted at edge T. `rd_empty`=0 and `rd_count` incremented are visible after that edge. `fifo_almost_full` updates one edge later.
- **Read latency:** `rd_en` sampled high at edge T with `rd_empty`=0. `rd_data` and its flags are valid after edge T+1 and held until the next accepted read.
- `frame_done` is high for exactly the cycle after an `ealign` edge.
- Sticky flags are cleared only by reset.

## Test plan
- **Reset:** assert `aresetn`=0 mid-stream -> all outputs at reset values; `rd_empty`=1; `rd_count`=0.
- **Full words:** pixels 0x000001..0x000008, `falign` on the first -> two words:
  - word0 = 0x00000004_00000003_00000002_00000001, sof=1;
  - word1 = 0x00000008_00000007_00000006_00000005, sof=0;
  - `rd_count`=2.
- **Line end:** 6-pixel line, `lalign` on pixel 6 -> word1 = 0x00000000_00000000_00000006_00000005, eol=1.
- **Frame end:** 3 pixels then `ealign` -> one word with slot 3 zero, eof=1; `frame_done` high 1 cycle later. A second `ealign` -> no push.
- **Fill/overflow:** push 17 words with no reads ->
  - `fifo_almost_full` rises one edge after `rd_count` reaches 12;
  - word 17 dropped; `overflow`=1; `rd_count`=16;
  - 16 reads return words 1..16 in order, then `rd_empty`=1.
- **Early falign:** 2 pixels, then a `falign` pixel 0xABCDEF -> no push; `frame_err`=1; the next word has slot0 = 0x00ABCDEF and sof=1.
